// File: rtl/led_blink_sched.sv
// Multi-channel LED blink scheduler driven by a shared millisecond tick.
// Ports: clk, reset (async high), start/stop per channel, ms_cfg half-periods,
//   burst_len (only with LED_BURST_EN), led/busy/done per channel.
// Optional macro LED_BURST_EN: per-channel burst of N blinks, then done pulse.
module led_blink_sched #(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   start,
  input  logic [N_CH-1:0]   stop,
  input  logic [16*N_CH-1:0] ms_cfg,
`ifdef LED_BURST_EN
  input  logic [8*N_CH-1:0] burst_len,
`endif
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  logic [PW-1:0] r_pre;
  logic          w_tick;

  assign w_tick = (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_pre <= '0;
    else if (w_tick)
      r_pre <= '0;
    else
      r_pre <= r_pre + 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t      r_st, w_st_nxt;
    logic [15:0] r_per, w_per_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_led, w_led_nxt;
    logic [15:0] w_cfg;
    logic [15:0] w_cfg_per;
    logic        w_term;

    assign w_cfg     = ms_cfg[16*g +: 16];
    // A zero half-period would never terminate; treat it as 1 ms.
    assign w_cfg_per = (w_cfg == 16'd0) ? 16'd1 : w_cfg;
    assign w_term    = (r_cnt == r_per - 16'd1);

`ifdef LED_BURST_EN
    logic [7:0] r_bn, w_bn_nxt;
    logic [8:0] r_tg, w_tg_nxt;
    logic [8:0] w_tg_inc;

    assign w_tg_inc = r_tg + 9'd1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_bn <= '0;
        r_tg <= '0;
      end else begin
        r_bn <= w_bn_nxt;
        r_tg <= w_tg_nxt;
      end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_st  <= S_IDLE;
        r_per <= '0;
        r_cnt <= '0;
        r_led <= 1'b0;
      end else begin
        r_st  <= w_st_nxt;
        r_per <= w_per_nxt;
        r_cnt <= w_cnt_nxt;
        r_led <= w_led_nxt;
      end
    end

    always_comb begin
      w_st_nxt  = r_st;
      w_per_nxt = r_per;
      w_cnt_nxt = r_cnt;
      w_led_nxt = r_led;
`ifdef LED_BURST_EN
      w_bn_nxt  = r_bn;
      w_tg_nxt  = r_tg;
`endif
      unique case (r_st)
        S_IDLE: begin
          w_led_nxt = 1'b0;
          if (!stop[g] && start[g]) begin
            w_st_nxt  = S_RUN;
            w_per_nxt = w_cfg_per;
            w_cnt_nxt = '0;
`ifdef LED_BURST_EN
            w_bn_nxt  = burst_len[8*g +: 8];
            w_tg_nxt  = '0;
`endif
          end
        end
        S_RUN: begin
          if (stop[g]) begin
            w_st_nxt  = S_IDLE;
            w_led_nxt = 1'b0;
          end else if (start[g]) begin
            w_per_nxt = w_cfg_per;
            w_cnt_nxt = '0;
            w_led_nxt = 1'b0;
`ifdef LED_BURST_EN
            w_bn_nxt  = burst_len[8*g +: 8];
            w_tg_nxt  = '0;
`endif
          end else if (w_tick) begin
            if (w_term) begin
              w_cnt_nxt = '0;
              w_led_nxt = ~r_led;
`ifdef LED_BURST_EN
              w_tg_nxt  = w_tg_inc;
              // The 2N-th toggle always lands on led=0; finish the burst there.
              if (r_bn != 8'd0 && w_tg_inc == {r_bn, 1'b0})
                w_st_nxt = S_DONE;
`endif
            end else begin
              w_cnt_nxt = r_cnt + 16'd1;
            end
          end
        end
        S_DONE: begin
          w_st_nxt  = S_IDLE;
          w_led_nxt = 1'b0;
        end
        default: begin
          w_st_nxt  = S_IDLE;
          w_led_nxt = 1'b0;
        end
      endcase
    end

    assign led[g]  = r_led;
    assign busy[g] = (r_st != S_IDLE);
`ifdef LED_BURST_EN
    assign done[g] = (r_st == S_DONE);
`else
    assign done[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched: directed table, hand sequences, random vs model.
// Model tracks ms ticks seen in RUN; led = odd(ticks / period).
module tb_led_blink_sched;
  localparam int N  = 4;
  localparam int TD = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   start = '0;
  logic [N-1:0]   stop = '0;
  logic [16*N-1:0] ms_cfg = '0;
`ifdef LED_BURST_EN
  logic [8*N-1:0] burst_len = '0;
`endif
  logic [N-1:0]   led;
  logic [N-1:0]   busy;
  logic [N-1:0]   done;

  int n_chk = 0;
  int n_fail = 0;

  led_blink_sched #(.N_CH(N), .TICK_DIV(TD)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .ms_cfg(ms_cfg),
`ifdef LED_BURST_EN
    .burst_len(burst_len),
`endif
    .led(led),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  bit m_run[N];
  bit m_done[N];
  int m_p[N];
  int m_k[N];
  int m_n[N];
  int mcyc;

  function automatic int get_bl(int i);
`ifdef LED_BURST_EN
    return int'(burst_len[8*i +: 8]);
`else
    return i - i;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_done[i] = 0;
      m_p[i] = 1; m_k[i] = 0; m_n[i] = 0;
    end
    mcyc = 0;
  endtask

  task automatic model_step();
    bit tick;
    int c;
    tick = ((mcyc % TD) == TD - 1);
    mcyc++;
    for (int i = 0; i < N; i++) begin
      if (m_done[i]) begin
        m_done[i] = 0;
      end else if (stop[i]) begin
        m_run[i] = 0;
      end else if (start[i]) begin
        c = int'(ms_cfg[16*i +: 16]);
        m_run[i] = 1;
        m_p[i] = (c == 0) ? 1 : c;
        m_k[i] = 0;
        m_n[i] = get_bl(i);
      end else if (m_run[i] && tick) begin
        m_k[i]++;
        if (m_n[i] != 0 && (m_k[i] / m_p[i]) == 2 * m_n[i]) begin
          m_run[i] = 0;
          m_done[i] = 1;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] exp_led();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++)
      v[i] = m_run[i] && (((m_k[i] / m_p[i]) % 2) == 1);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_busy();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_run[i] | m_done[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_done();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_done[i];
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("led", 32'(led), 32'(exp_led()));
    check("busy", 32'(busy), 32'(exp_busy()));
    check("done", 32'(done), 32'(exp_done()));
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = '0;
    stop = '0;
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int          ch;
    logic [15:0] cfg;
    int          s;
    logic        e_led;
    logic        e_busy;
  } vec_t;

  vec_t tbl[8];
  int   tg;
  int   dp;
  logic pl;

  initial begin
    tbl[0] = '{0, 16'd3, 28, 1'b0, 1'b1};
    tbl[1] = '{0, 16'd3, 29, 1'b1, 1'b1};
    tbl[2] = '{0, 16'd3, 58, 1'b1, 1'b1};
    tbl[3] = '{0, 16'd3, 59, 1'b0, 1'b1};
    tbl[4] = '{1, 16'd0, 8, 1'b0, 1'b1};
    tbl[5] = '{1, 16'd0, 9, 1'b1, 1'b1};
    tbl[6] = '{1, 16'd0, 19, 1'b0, 1'b1};
    tbl[7] = '{2, 16'd1, 9, 1'b1, 1'b1};

    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    check("reset_led", 32'(led), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      ms_cfg = '0;
      ms_cfg[16*tbl[r].ch +: 16] = tbl[r].cfg;
      start[tbl[r].ch] = 1'b1;
      step();
      start = '0;
      ms_cfg[16*tbl[r].ch +: 16] = 16'd9;
      repeat (tbl[r].s) step();
      check("tbl_led", 32'(led[tbl[r].ch]), 32'(tbl[r].e_led));
      check("tbl_busy", 32'(busy[tbl[r].ch]), 32'(tbl[r].e_busy));
    end

    do_reset();
    ms_cfg[32 +: 16] = 16'd1;
    start[2] = 1'b1;
    step();
    start = '0;
    repeat (25) step();
    check("ch2_running", 32'(busy[2]), 32'h1);
    start[2] = 1'b1;
    stop[2] = 1'b1;
    step();
    start = '0;
    stop = '0;
    check("start_stop_led", 32'(led[2]), 32'h0);
    check("start_stop_busy", 32'(busy[2]), 32'h0);

    do_reset();
    for (int i = 0; i < N; i++) ms_cfg[16*i +: 16] = 16'(i + 1);
`ifdef LED_BURST_EN
    burst_len = '0;
`endif
    start = '1;
    step();
    start = '0;
    repeat (47) step();
    check("all_busy", 32'(busy), 32'hf);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_led", 32'(led), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) step();
    check("post_reset_idle", 32'(busy), 32'h0);

`ifdef LED_BURST_EN
    do_reset();
    ms_cfg[48 +: 16] = 16'd2;
    burst_len[24 +: 8] = 8'd2;
    start[3] = 1'b1;
    step();
    start = '0;
    tg = 0;
    dp = 0;
    pl = led[3];
    for (int c = 0; c < 200 && busy[3]; c++) begin
      step();
      if (led[3] != pl) tg++;
      pl = led[3];
      if (done[3]) dp++;
    end
    check("burst_toggles", 32'(tg), 32'd4);
    check("burst_done_pulses", 32'(dp), 32'd1);
    check("burst_idle", 32'(busy[3]), 32'h0);
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        start[i] = ($urandom % 40) == 0;
        stop[i] = ($urandom % 70) == 0;
        if (($urandom % 8) == 0)
          ms_cfg[16*i +: 16] = 16'($urandom % 4);
`ifdef LED_BURST_EN
        if (($urandom % 8) == 0)
          burst_len[8*i +: 8] = 8'($urandom % 3);
`endif
      end
      step();
    end
    start = '0;
    stop = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_blink_sched.md
LED_BLINK_SCHED -- requirements
Module: led_blink_sched

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, number of independent LED channels.
REQ-002 The block SHALL have parameter TICK_DIV, default 100000, clk cycles per millisecond tick (100 MHz clock).
REQ-003 The block SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  N_CH  per-channel start/restart request, sampled each cycle.
REQ-006 The block SHALL have port stop  input  N_CH  per-channel stop request, sampled each cycle.
REQ-007 The block SHALL have port ms_cfg  input  16*N_CH  per-channel half-period in ms; channel i uses bits [16i+15:16i].
REQ-008 The block SHALL have port burst_len  input  8*N_CH  per-channel blink count; present only when LED_BURST_EN is defined.
REQ-009 The block SHALL have port led  output  N_CH  LED drive, registered.
REQ-010 The block SHALL have port busy  output  N_CH  high while the channel is not IDLE.
REQ-011 The block SHALL have port done  output  N_CH  one-cycle pulse on burst completion.

Function
REQ-012 One shared free-running prescaler SHALL count 0..TICK_DIV-1 and raise internal ms_tick for exactly one cycle when count equals TICK_DIV-1, then wrap to 0.
REQ-013 Each channel SHALL run an independent FSM with states IDLE, RUN, DONE.
REQ-014 IDLE: led=0, busy=0; on start[i] the channel SHALL latch ms_cfg slice into period_i (value 0 latched as 1), clear ms_cnt_i, clear toggle count, enter RUN next cycle.
REQ-015 RUN: on each ms_tick, if ms_cnt_i == period_i-1 the channel SHALL invert led[i] and clear ms_cnt_i, else increment ms_cnt_i; led[i] changes in the cycle after the terminal ms_tick.
REQ-016 First toggle in RUN SHALL occur on the period_i-th ms_tick after entry; ms_cfg changes while RUN SHALL have no effect until next start.
REQ-017 stop[i] in any state SHALL force IDLE, led[i]=0, next cycle; stop SHALL win over start in the same cycle.
REQ-018 start[i] while RUN SHALL restart: relatch period, clear counters, led[i]=0.
REQ-019 ms_cnt_i SHALL be 16 bits; no overflow occurs since it never exceeds period_i-1.
REQ-020 DONE (burst only): led[i]=0, done[i]=1 for that single cycle, then IDLE unconditionally next cycle.
REQ-021 Channels SHALL not interact; simultaneous starts on all channels SHALL be accepted in one cycle.

Reset
REQ-022 reset SHALL asynchronously clear prescaler, all counters, periods; FSMs to IDLE; led=0, busy=0, done=0.
REQ-023 Reset asserted mid-RUN SHALL abort immediately; after release, channels stay IDLE until a new start.

Configuration
REQ-024 Macro LED_BURST_EN defined: start latches burst_len slice as N; N=0 means continuous; after 2*N toggles (N complete on/off blinks) RUN SHALL enter DONE instead of toggling further.
REQ-025 LED_BURST_EN undefined: burst_len port absent, channels blink continuously until stop, DONE state unreachable, done held 0.

Verification (TICK_DIV=10 for simulation)
REQ-026 Reset, then start[0] with ms_cfg[0]=3 -> led[0] first rises 30 cycles after entering RUN (aligned to ms_tick), toggles every 30 cycles; busy[0]=1.
REQ-027 ms_cfg[1]=0, start[1] -> led[1] toggles every ms_tick (10 cycles).
REQ-028 Channel 2 running, start[2] and stop[2] same cycle -> IDLE, led[2]=0, busy[2]=0 next cycle.
REQ-029 LED_BURST_EN, ms_cfg[3]=2, burst_len[3]=2 -> exactly 4 toggles, then done[3] one-cycle pulse, busy[3] falls the following cycle.
REQ-030 Reset pulse while all four channels run -> all led/busy low immediately (async), no activity after release until new start.
